stream_mux2_arb: RTL and testbench
==================================

Name: stream_mux2_arb

Overview:
- Two-input to one-output stream merger with valid/ready handshakes, packet-granular round-robin arbitration and a registered output stage.
- Collects traffic that the 1-to-2 demultiplexer fanned out and returns it to one shared datapath.
- out_src tags each beat with its origin, so a downstream 1-to-2 demux can route responses back using out_src as its select.

Parameters:
- W, 16, data width of every data port.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in0_data  input  W  channel 0 data.
- in0_valid  input  1  channel 0 beat present.
- in0_last  input  1  channel 0 final beat of packet.
- in0_ready  output  1  channel 0 beat accepted this cycle when high with in0_valid.
- in1_data  input  W  channel 1 data.
- in1_valid  input  1  channel 1 beat present.
- in1_last  input  1  channel 1 final beat of packet.
- in1_ready  output  1  channel 1 beat accepted this cycle when high with in1_valid.
- out_data  output  W  merged data (registered).
- out_valid  output  1  output beat present (registered).
- out_last  output  1  final beat of packet (registered).
- out_src  output  1  origin of current beat: 0 = in0, 1 = in1 (registered).
- out_ready  input  1  downstream accepts output beat.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous, active-high, and has priority over all other inputs.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - FSM=IDLE, priority pointer prio=0 (in0 favoured).
  - in0_ready=in1_ready=0 while rst=1.
- Handshakes:
  - A transfer occurs on a cycle where valid&ready are both high.
  - Upstream valid/data/last must be held until accepted.
  - The output holds out_data/out_last/out_src stable while out_valid=1 and out_ready=0.
- space:
  - space = !out_valid | out_ready (combinational).
  - in*_ready are combinational from the FSM state, the in*_valid signals, prio and space. There is no combinational path from in*_data to any output.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE grant:
  - Only in0_valid → grant 0.
  - Only in1_valid → grant 1.
  - Both valid → grant = prio.
  - Granted channel's ready = space; the other ready = 0.
- IDLE transitions on an accepted beat:
  - last=0 → LOCKn (n = granted channel).
  - last=1 → stay IDLE, prio = !n.
- LOCKn:
  - inN_ready = space; the other channel's ready = 0 regardless of its valid.
  - Accepted beat with last=1 → IDLE, prio = !n.
  - Channel n may idle (valid=0) mid-packet. The lock holds indefinitely; there is no timeout.
- Output register, on an accepted beat:
  - out_data, out_last and out_src load next edge; out_valid=1.
  - Else if out_ready → out_valid=0; data, last and src keep their values.
- Latency and throughput:
  - Latency: 1 cycle from input acceptance to out_valid.
  - Throughput: 1 beat/cycle sustained when out_ready=1 (simultaneous consume and load in the same cycle).
- Fairness: with both channels continuously requesting, packets alternate in0, in1, in0, ...
- Single-beat packets (last=1 on first beat) never enter LOCK.
- Reset mid-packet:
  - The in-flight output beat is dropped (out_valid=0) and the FSM returns to IDLE with prio=0.
  - Upstream senders must restart their packets.
- Both inputs valid with out_ready=0 and out_valid=1: no beat is accepted and no state changes.

Test Plan:
- Reset then in0 single beat 0x1234, last=1, out_ready=1 → in0_ready=1 that cycle; next cycle out_valid=1, out_data=0x1234, out_src=0, out_last=1; FSM stays IDLE, prio=1.
- Both channels continuously present 2-beat packets (in0: 0xA000, 0xA001; in1: 0xB000, 0xB001), out_ready=1 → output sequence A000, A001, B000, B001, A000, ...; out_src 0,0,1,1,0; no gaps.
- in0 sends 3-beat packet with valid low for 2 cycles after beat 1 while in1_valid=1 → in1_ready stays 0; output A-beats contiguous as a packet, then in1's packet.
- out_ready=0 for 4 cycles with out_valid=1 (data 0x00FF) → out_data, out_last and out_src stable; in0_ready=in1_ready=0; no beats lost or duplicated after out_ready returns to 1.
- rst asserted in LOCK1 after 1 of 3 beats → next cycle out_valid=0, FSM=IDLE, prio=0; simultaneous fresh requests then grant in0 first.
- Both valid in the same cycle immediately after reset → in0 granted; after its last beat, in1 granted even though in0 is still requesting.

Source files
------------

// File: rtl/stream_mux2_arb_if.sv
// Signal bundle for the two-input stream merger: two upstream channels plus
// the merged, source-tagged downstream channel.
interface stream_mux2_arb_if #(
  parameter int W = 16
);
  logic [W-1:0] in0_data;
  logic         in0_valid;
  logic         in0_last;
  logic         in0_ready;
  logic [W-1:0] in1_data;
  logic         in1_valid;
  logic         in1_last;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_src;
  logic         out_ready;

  modport master (
    output in0_data, in0_valid, in0_last,
    input  in0_ready,
    output in1_data, in1_valid, in1_last,
    input  in1_ready,
    input  out_data, out_valid, out_last, out_src,
    output out_ready
  );

  modport slave (
    input  in0_data, in0_valid, in0_last,
    output in0_ready,
    input  in1_data, in1_valid, in1_last,
    output in1_ready,
    output out_data, out_valid, out_last, out_src,
    input  out_ready
  );
endinterface

// File: rtl/stream_mux2_arb.sv
// Two-to-one stream merger with packet-granular round-robin arbitration and a
// registered output stage; out_src tags every beat with its origin channel.
module stream_mux2_arb #(
  parameter int W = 16
) (
  input logic              clk,
  input logic              rst,
  stream_mux2_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         prio_q, prio_d;
  logic         space;
  logic         sel;
  logic         grant_any;
  logic         accept;
  logic         acc_last;
  logic [W-1:0] acc_data;
  logic [W-1:0] out_data_q;
  logic         out_valid_q;
  logic         out_last_q;
  logic         out_src_q;

  assign space = !out_valid_q || bus.out_ready;

  // Once a packet has started, the lock keeps the other channel out even
  // while the owner idles, so packets are never interleaved.
  always_comb begin
    sel       = 1'b0;
    grant_any = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in0_valid && (!bus.in1_valid || !prio_q)) begin
          sel       = 1'b0;
          grant_any = 1'b1;
        end else if (bus.in1_valid) begin
          sel       = 1'b1;
          grant_any = 1'b1;
        end
      end
      LOCK0: begin
        sel       = 1'b0;
        grant_any = 1'b1;
      end
      LOCK1: begin
        sel       = 1'b1;
        grant_any = 1'b1;
      end
      default: begin
        sel       = 1'b0;
        grant_any = 1'b0;
      end
    endcase
  end

  assign bus.in0_ready = !rst && grant_any && !sel && space;
  assign bus.in1_ready = !rst && grant_any &&  sel && space;

  assign accept   = (bus.in0_valid && bus.in0_ready) || (bus.in1_valid && bus.in1_ready);
  assign acc_data = sel ? bus.in1_data : bus.in0_data;
  assign acc_last = sel ? bus.in1_last : bus.in0_last;

  // Finishing a packet hands priority to the other channel.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (accept) begin
      if (acc_last) begin
        state_d = IDLE;
        prio_d  = !sel;
      end else begin
        state_d = sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Load and drain may coincide, which gives one beat per cycle when unstalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_data;
      out_last_q  <= acc_last;
      out_src_q   <= sel;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux2_arb.sv
// Directed, table-driven bench for stream_mux2_arb plus hand-written sequences
// for sustained streaming through a lock and the hand-over that follows.
module tb_stream_mux2_arb;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  stream_mux2_arb_if #(.W(16)) bus ();

  stream_mux2_arb #(.W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic        l0;
    logic [15:0] d0;
    logic        v1;
    logic        l1;
    logic [15:0] d1;
    logic        ordy;
    logic        e_r0;
    logic        e_r1;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_ol;
    logic        e_os;
  } vec_t;

  vec_t vecs [27];

  task automatic applyStimulus(input vec_t v);
    rst           = v.rst;
    bus.in0_valid = v.v0;
    bus.in0_last  = v.l0;
    bus.in0_data  = v.d0;
    bus.in1_valid = v.v1;
    bus.in1_last  = v.l1;
    bus.in1_data  = v.d1;
    bus.out_ready = v.ordy;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic found;

    // rst v0 l0 d0 v1 l1 d1 ordy | r0 r1 ov od ol os
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'hA000, 1'b1, 1'b0, 16'hB000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'hA001, 1'b1, 1'b0, 16'hB000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'hA000, 1'b1, 1'b0, 16'hB000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hB000, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'hA000, 1'b1, 1'b1, 16'hB001, 1'b1, 1'b0, 1'b1, 1'b1, 16'hB001, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'hA000, 1'b1, 1'b1, 16'hB000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hB000, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hB000, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'hA001, 1'b1, 1'b1, 16'hB000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA001, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 16'hA002, 1'b1, 1'b1, 16'hB000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA002, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hB000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hB000, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0200, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hC000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC000, 1'b0, 1'b1};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 16'hD000, 1'b1, 1'b0, 16'hC001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 1'b1, 16'hD000, 1'b1, 1'b1, 16'hC000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hD000, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 1'b1, 16'hD000, 1'b1, 1'b1, 16'hC000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC000, 1'b1, 1'b1};
    vecs[26] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC000, 1'b1, 1'b1};

    applyStimulus(vecs[0]);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d_in0_ready", i), {15'd0, bus.in0_ready}, {15'd0, vecs[i].e_r0});
      checkOutput($sformatf("row%0d_in1_ready", i), {15'd0, bus.in1_ready}, {15'd0, vecs[i].e_r1});
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d_out_valid", i), {15'd0, bus.out_valid}, {15'd0, vecs[i].e_ov});
      checkOutput($sformatf("row%0d_out_data", i), bus.out_data, vecs[i].e_od);
      checkOutput($sformatf("row%0d_out_last", i), {15'd0, bus.out_last}, {15'd0, vecs[i].e_ol});
      checkOutput($sformatf("row%0d_out_src", i), {15'd0, bus.out_src}, {15'd0, vecs[i].e_os});
    end

    // Eight-beat in0 packet streamed back to back while in1 waits on 0x9999.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      bus.in0_valid = 1'b1;
      bus.in0_data  = 16'h7000 + 16'(i);
      bus.in0_last  = (i == 7);
      bus.in1_valid = 1'b1;
      bus.in1_data  = 16'h9999;
      bus.in1_last  = 1'b1;
      #1;
      checkOutput($sformatf("burst%0d_in0_ready", i), {15'd0, bus.in0_ready}, 16'd1);
      checkOutput($sformatf("burst%0d_in1_ready", i), {15'd0, bus.in1_ready}, 16'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("burst%0d_out_valid", i), {15'd0, bus.out_valid}, 16'd1);
      checkOutput($sformatf("burst%0d_out_data", i), bus.out_data, 16'h7000 + 16'(i));
      checkOutput($sformatf("burst%0d_out_last", i), {15'd0, bus.out_last}, (i == 7) ? 16'd1 : 16'd0);
    end

    @(negedge clk);
    bus.in0_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid && bus.out_src) begin
        found = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.in1_valid = 1'b0;
    checkOutput("handover_seen", {15'd0, found}, 16'd1);
    checkOutput("handover_data", bus.out_data, 16'h9999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
